// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite read initiator: response encodings,
// the response record layout at the default data width, and a small helper
// that classifies an R-channel response code.
package axil_pkg;

    localparam int AXIL_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Response record as seen by the core at the default data width.
    typedef struct packed {
        logic                       err;
        logic [AXIL_DATA_WIDTH-1:0] data;
    } axil_rsp_t;

    // True for the two error encodings; the upper bit alone tells them apart
    // from OKAY/EXOKAY, written out so both bits are visibly considered.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_rd_master_chk.sv
// Safety properties of the read initiator, kept apart from the datapath.
module axil_rd_master_chk #(
    parameter int MAX_OUTST = 4,
    parameter int CW        = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          r_beat,
    input logic          fifo_full,
    input logic [CW-1:0] credit
);

    // Credits reserve a slot for every beat, so an R beat never meets a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_beat && fifo_full));

    // Outstanding count stays within the configured window.
    a_credit_bound: assert property (@(posedge clk) disable iff (rst) credit <= CW'(MAX_OUTST));

endmodule

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata whenever
// the FIFO is not empty. Depth need not be a power of two.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return {PW{1'b0}};
        end else begin
            return p + 1'b1;
        end
    endfunction

    assign empty   = (count_r == {CNTW{1'b0}});
    assign full    = (count_r == CNT_FULL);
    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;
    assign rdata   = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axil_rd_master.sv
// AXI4-Lite read initiator. Core requests become AR transactions through a
// single-entry AR register; R beats land in an in-order response FIFO.
// A credit counter bounds reads in flight to the FIFO depth, which is why
// axi_rready can stay high.
// Optional build macro AXIL_RD_ALIGN_CHK_EN: misaligned requests are answered
// locally with an error response (no AR), after all older reads drain.
module axil_rd_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTST);

    logic [CW-1:0]         credit_r;
    logic                  ar_valid_r;
    logic [ADDR_WIDTH-1:0] ar_addr_r;
    logic                  err_push_r;
    logic                  misal_s;
    logic                  req_ready_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  r_beat_s;
    logic                  push_s;
    logic [EW-1:0]         push_data_s;
    logic [EW-1:0]         head_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  rsp_valid_s;

`ifdef AXIL_RD_ALIGN_CHK_EN
    localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_LSB) - 1);
    assign misal_s = ((req_addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
`else
    assign misal_s = 1'b0;
`endif

    // Request acceptance: a free credit and a free (or freeing) AR slot; a
    // misaligned request also waits for an idle pipe so its error stays in order.
    always_comb begin
        req_ready_s = 1'b0;
        if (credit_r < CREDIT_MAX) begin
            if (misal_s) begin
                req_ready_s = (credit_r == {CW{1'b0}}) && !ar_valid_r;
            end else begin
                req_ready_s = !ar_valid_r || axi_arready;
            end
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign req_ready   = req_ready_s;
    assign accept_s    = req_valid & req_ready_s;
    assign rsp_valid_s = ~fifo_empty_s;
    assign pop_s       = rsp_valid_s & rsp_ready;
    assign axi_rready  = ~rst;
    assign r_beat_s    = axi_rvalid & ~rst;

    // Outstanding-read credit: up on accept, down on pop, unchanged on both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credit_r <= credit_r + 1'b1;
                2'b01:   credit_r <= credit_r - 1'b1;
                default: credit_r <= credit_r;
            endcase
        end
    end

    // AR stage: loads on an issuing accept, holds until the handshake, and
    // reloads in the handshake cycle for back-to-back issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_valid_r <= 1'b0;
            ar_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s && !misal_s) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= req_addr;
        end else if (axi_arready) begin
            ar_valid_r <= 1'b0;
        end else begin
            ar_valid_r <= ar_valid_r;
        end
    end

    // Locally generated error entry, pushed the cycle after a misaligned accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_push_r <= 1'b0;
        end else begin
            err_push_r <= accept_s & misal_s;
        end
    end

    // FIFO write selection: local error entry or an R beat, data zeroed on error.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = {EW{1'b0}};
        if (err_push_r) begin
            push_s      = 1'b1;
            push_data_s = {1'b1, {DATA_WIDTH{1'b0}}};
        end else if (r_beat_s) begin
            push_s = 1'b1;
            if (resp_is_err(axi_rresp)) begin
                push_data_s = {1'b1, {DATA_WIDTH{1'b0}}};
            end else begin
                push_data_s = {1'b0, axi_rdata};
            end
        end else begin
            push_s      = 1'b0;
            push_data_s = {EW{1'b0}};
        end
    end

    sync_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (EW)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (push_data_s),
        .pop   (pop_s),
        .rdata (head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    axil_rd_master_chk #(
        .MAX_OUTST (MAX_OUTST),
        .CW        (CW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .r_beat    (r_beat_s),
        .fifo_full (fifo_full_s),
        .credit    (credit_r)
    );

    assign axi_arvalid = ar_valid_r;
    assign axi_araddr  = ar_addr_r;
    assign rsp_valid   = rsp_valid_s;
    assign rsp_data    = rsp_valid_s ? head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    assign rsp_err     = rsp_valid_s & head_s[DATA_WIDTH];

endmodule

// File: tb/tb_axil_rd_master.sv
`timescale 1ns/1ps
module tb_axil_rd_master;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready = 1'b1;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    axil_rd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- slave memory map owned by the bench ----------------
    function automatic logic [31:0] slv_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        if (a[12]) return 2'b11;
        if (a[11]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic misal(input logic [31:0] a);
`ifdef AXIL_RD_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Zero-wait slave: R beat the cycle after each AR handshake, in order.
    initial begin
        logic [31:0] sq[$];
        logic hs, beat;
        logic [31:0] hs_addr;
        axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b00;
        forever begin
            @(negedge clk);
            hs = axi_arvalid && axi_arready;
            hs_addr = axi_araddr;
            beat = axi_rvalid && axi_rready;
            @(posedge clk); #2;
            if (rst) begin
                sq.delete();
                axi_rvalid = 1'b0;
            end else begin
                if (beat && sq.size() > 0) void'(sq.pop_front());
                if (hs) sq.push_back(hs_addr);
                if (sq.size() > 0) begin
                    axi_rvalid = 1'b1;
                    axi_rdata  = slv_data(sq[0]);
                    axi_rresp  = slv_resp(sq[0]);
                end else begin
                    axi_rvalid = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model: in-order expected responses ----------------
    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    int          ar_cnt = 0;
    logic        prev_ar_stall = 1'b0;
    logic [31:0] prev_araddr = 32'h0;
    logic        prev_rsp_hold = 1'b0;
    logic [31:0] prev_rdata = 32'h0;
    logic        prev_rerr = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst) begin
            exp_q.delete(); ar_q.delete();
            prev_ar_stall = 1'b0; prev_rsp_hold = 1'b0;
            check("rst_arvalid", axi_arvalid, 0);
            check("rst_araddr", axi_araddr, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_rready", axi_rready, 0);
        end else begin
            check("rready_high", axi_rready, 1);
            exp_rdy = (exp_q.size() < MAXO) && (!axi_arvalid || axi_arready);
            if (misal(req_addr)) exp_rdy = exp_rdy && (exp_q.size() == 0) && !axi_arvalid;
            check("req_ready", req_ready, exp_rdy);
            if (prev_ar_stall) begin
                check("ar_hold_valid", axi_arvalid, 1);
                check("ar_hold_addr", axi_araddr, prev_araddr);
            end
            prev_ar_stall = axi_arvalid && !axi_arready;
            prev_araddr = axi_araddr;
            if (axi_arvalid && axi_arready) begin
                ar_cnt++;
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("ar_addr", axi_araddr, ar_q.pop_front());
            end
            if (prev_rsp_hold) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", rsp_data, prev_rdata);
                check("rsp_hold_err", rsp_err, prev_rerr);
            end
            prev_rsp_hold = rsp_valid && !rsp_ready;
            prev_rdata = rsp_data;
            prev_rerr = rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", rsp_err, e.err);
                end
            end
            if (req_valid && req_ready) begin
                if (misal(req_addr)) begin
                    e.data = 32'h0; e.err = 1'b1;
                end else begin
                    e.err  = slv_resp(req_addr) >= 2'b10;
                    e.data = e.err ? 32'h0 : slv_data(req_addr);
                    ar_q.push_back(req_addr);
                end
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] a, input int max_wait, output bit ok);
        int i = 0;
        ok = 1'b0;
        req_valid = 1'b1; req_addr = a;
        while (!ok && i < max_wait) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic wait_empty();
        int i = 0;
        while ((exp_q.size() != 0 || rsp_valid) && i < 60) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } vec_t;

    task automatic single_read(input vec_t v);
        bit ok;
        int lat;
        logic got;
        rsp_ready = 1'b1; axi_arready = 1'b1;
        send(v.addr, 4, ok);
        req_valid = 1'b0;
        check("single_accept", ok, 1);
        lat = 1;
        @(negedge clk);
        check("single_arvalid", axi_arvalid, 1);
        check("single_araddr", axi_araddr, v.addr);
        got = rsp_valid;
        while (!got && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
            got = rsp_valid;
        end
        check("single_latency", lat, 3);
        check("single_data", rsp_data, v.data);
        check("single_err", rsp_err, v.err);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        logic [31:0] a6[6];
        bit ok;
        int base;
        logic [31:0] ra;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0800, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h0000_0014, 32'h0014_FFEB, 1'b0};
        vecs[3] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_1804, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_E7FC, 32'hE7FC_1803, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_FFFF, 1'b0};
        a6 = '{32'h20, 32'h24, 32'h828, 32'h2C, 32'h30, 32'h34};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed single reads, including error responses followed by OKAY.
        for (int i = 0; i < 6; i++) single_read(vecs[i]);

        // Six back-to-back requests with the core not popping.
        rsp_ready = 1'b0; axi_arready = 1'b1; base = ar_cnt;
        for (int i = 0; i < 4; i++) begin
            send(a6[i], 2, ok);
            check("b2b_accept", ok, 1);
        end
        req_addr = a6[4];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("full_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        check("full_ar_count", ar_cnt - base, 4);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pop_at_full_ready", req_ready, 0);
        check("pop_at_full_valid", rsp_valid, 1);
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk); check("after_pop_ready", req_ready, 1);
        @(posedge clk); #1; req_addr = a6[5];
        @(negedge clk); check("refull_ready", req_ready, 0);
        @(posedge clk); #1; @(posedge clk); #1;
        check("after_pop_ar_count", ar_cnt - base, 5);
        rsp_ready = 1'b1;
        send(a6[5], 10, ok);
        req_valid = 1'b0;
        check("b2b_last_accept", ok, 1);
        wait_empty();

        // AR stalled for five cycles with a second request waiting.
        rsp_ready = 1'b1; axi_arready = 1'b0; base = ar_cnt;
        send(32'h0000_0100, 2, ok);
        check("stall_accept", ok, 1);
        req_addr = 32'h0000_0104;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_arvalid", axi_arvalid, 1);
            check("stall_araddr", axi_araddr, 32'h0000_0100);
            check("stall_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        check("stall_no_ar", ar_cnt - base, 0);
        axi_arready = 1'b1;
        @(negedge clk); check("reload_ready", req_ready, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        check("reload_arvalid", axi_arvalid, 1);
        check("reload_araddr", axi_araddr, 32'h0000_0104);
        @(posedge clk); #1;
        wait_empty();
        check("stall_ar_total", ar_cnt - base, 2);

        // Reset with three reads outstanding.
        rsp_ready = 1'b0; axi_arready = 1'b1;
        send(32'h200, 2, ok); send(32'h204, 2, ok); send(32'h208, 2, ok);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_arvalid", axi_arvalid, 0);
        check("mid_rst_araddr", axi_araddr, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        check("mid_rst_rready", axi_rready, 0);
        check("mid_rst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        single_read(vecs[6]);

        // Misaligned request.
`ifdef AXIL_RD_ALIGN_CHK_EN
        rsp_ready = 1'b0; axi_arready = 1'b1;
        send(32'h300, 2, ok); send(32'h304, 2, ok);
        req_addr = 32'h0000_0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("misal_stall", req_ready, 0);
            @(posedge clk); #1;
        end
        base = ar_cnt;
        rsp_ready = 1'b1;
        send(32'h0000_0002, 12, ok);
        req_valid = 1'b0;
        check("misal_accept", ok, 1);
        begin
            int k = 0;
            while (!rsp_valid && k < 10) begin @(posedge clk); #1; k++; end
            check("misal_err", rsp_err, 1);
            check("misal_data", rsp_data, 0);
        end
        wait_empty();
        check("misal_no_ar", ar_cnt - base, 0);
`else
        rsp_ready = 1'b1; axi_arready = 1'b1; base = ar_cnt;
        send(32'h0000_0002, 4, ok);
        req_valid = 1'b0;
        check("unal_accept", ok, 1);
        @(negedge clk);
        check("unal_arvalid", axi_arvalid, 1);
        check("unal_araddr", axi_araddr, 32'h0000_0002);
        @(posedge clk); #1;
        wait_empty();
        check("unal_ar_count", ar_cnt - base, 1);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            ra = $urandom & 32'h0000_1FFC;
            if ($urandom_range(0, 9) == 0) ra = ra | 32'($urandom_range(1, 3));
            req_valid   = ($urandom_range(0, 1) == 1);
            req_addr    = ra;
            axi_arready = ($urandom_range(0, 3) != 0);
            rsp_ready   = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; axi_arready = 1'b1; rsp_ready = 1'b1;
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
